lcd_bus_arbiter: RTL and testbench

//   Owns the 8-bit HD44780 LCD bus (data/EN/RW/RS). Runs the power-up init sequence, then

---
 rtl/lcd_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : lcd_bus_arbiter
// Owns the 8-bit HD44780 bus: power-up init, then round-robin byte writes.
// Rev    : 1.0
// ============================================================================
module lcd_bus_arbiter #(
   parameter int HALF_PERIOD = 50_000,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       busy,
   output logic       init_done,
   output logic [7:0] data,
   output logic       EN,
   output logic       RW,
   output logic       RS
);

   localparam logic [1:0] S_INIT     = 2'd0;
   localparam logic [1:0] S_IDLE     = 2'd1;
   localparam logic [1:0] S_PULSE_HI = 2'd2;
   localparam logic [1:0] S_PULSE_LO = 2'd3;

   localparam logic [CNT_W-1:0] C_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C_HALF_LAST    = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] C_LONG_LO_LAST = CNT_W'(2 * HALF_PERIOD - 1);
   localparam logic [1:0]       C_INIT_LAST    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [1:0]       init_idx_q, init_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_grant_q, last_grant_d;
   logic             init_done_q, init_done_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;

   logic             w_grant;
   logic             w_xfer;
   logic             w_long;
   logic [CNT_W-1:0] w_lo_last;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   // Tie goes to whichever requester was not served last.
   assign w_grant    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
   assign req0_ready = (state_q == S_IDLE) & init_done_q & req0_valid & ~w_grant;
   assign req1_ready = (state_q == S_IDLE) & init_done_q & req1_valid &  w_grant;
   assign w_xfer     = req0_ready | req1_ready;

   // Clear and home need the extra settle time in the low phase.
   assign w_long    = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));
   assign w_lo_last = w_long ? C_LONG_LO_LAST : C_HALF_LAST;

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      cnt_d        = cnt_q + C_ONE;
      last_grant_d = last_grant_q;
      init_done_d  = init_done_q;
      en_d         = en_q;
      rs_d         = rs_q;
      data_d       = data_q;

      case (state_q)
         S_INIT: begin
            init_idx_d = 2'd0;
            data_d     = init_byte(2'd0);
            rs_d       = 1'b0;
            en_d       = 1'b1;
            cnt_d      = '0;
            state_d    = S_PULSE_HI;
         end
         S_IDLE: begin
            cnt_d = '0;
            en_d  = 1'b0;
            if (w_xfer) begin
               data_d       = w_grant ? req1_data : req0_data;
               rs_d         = w_grant ? req1_rs : req0_rs;
               last_grant_d = w_grant;
               en_d         = 1'b1;
               state_d      = S_PULSE_HI;
            end
         end
         S_PULSE_HI: begin
            if (cnt_q == C_HALF_LAST) begin
               cnt_d   = '0;
               en_d    = 1'b0;
               state_d = S_PULSE_LO;
            end
         end
         default: begin
            if (cnt_q == w_lo_last) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!init_done_q) begin
                  if (init_idx_q == C_INIT_LAST) begin
                     init_done_d = 1'b1;
                  end else begin
                     init_idx_d = init_idx_q + 2'd1;
                     data_d     = init_byte(init_idx_q + 2'd1);
                     rs_d       = 1'b0;
                     en_d       = 1'b1;
                     state_d    = S_PULSE_HI;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         init_idx_q   <= 2'd0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         init_done_q  <= 1'b0;
         en_q         <= 1'b0;
         rs_q         <= 1'b0;
         data_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         init_done_q  <= init_done_d;
         en_q         <= en_d;
         rs_q         <= rs_d;
         data_q       <= data_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign init_done = init_done_q;
   assign data      = data_q;
   assign EN        = en_q;
   assign RW        = 1'b0;
   assign RS        = rs_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_bus_arbiter
// Bench for lcd_bus_arbiter: vector table, corner sequences, random vs byte-timer model.
// Rev    : 1.0
// ============================================================================
module tb_lcd_bus_arbiter;

   localparam int HP = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req0_rs = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req1_valid = 1'b0, req1_rs = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req0_ready, req1_ready, busy, init_done, EN, RW, RS;
   logic [7:0] data;

   always #5 clk = ~clk;

   lcd_bus_arbiter #(.HALF_PERIOD(HP), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
      .busy(busy), .init_done(init_done), .data(data), .EN(EN), .RW(RW), .RS(RS)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic r0, r1, en, busy, rs, idn;
      logic [7:0] data;
   } obs_t;

   // Byte-timer reference: each byte is a window of 2 or 3 half periods, EN high in the first.
   logic [7:0] m_initq[$];
   bit         m_starting, m_active, m_done, m_last, m_rs;
   logic [7:0] m_data;
   int         m_age, m_len, m_acc;

   task automatic m_reset();
      m_initq    = '{8'h38, 8'h0C, 8'h01, 8'h06};
      m_starting = 1'b1;
      m_active   = 1'b0;
      m_done     = 1'b0;
      m_last     = 1'b1;
      m_rs       = 1'b0;
      m_data     = 8'h00;
      m_age      = 0;
      m_len      = 0;
   endtask

   function automatic bit m_ready(input int g);
      if (m_starting || m_active || !m_done) return 1'b0;
      if (g == 0) return req0_valid && (!req1_valid || m_last == 1'b1);
      return req1_valid && (!req0_valid || m_last == 1'b0);
   endfunction

   task automatic m_load(input bit rs, input logic [7:0] d);
      m_rs     = rs;
      m_data   = d;
      m_age    = 0;
      m_len    = (!rs && (d == 8'h01 || d == 8'h02)) ? 3 * HP : 2 * HP;
      m_active = 1'b1;
   endtask

   task automatic m_step();
      if (rst) begin
         m_reset();
      end else if (m_starting) begin
         m_starting = 1'b0;
         m_load(1'b0, m_initq.pop_front());
      end else if (m_active) begin
         m_age++;
         if (m_age == m_len) begin
            m_active = 1'b0;
            if (!m_done) begin
               if (m_initq.size() == 0) m_done = 1'b1;
               else m_load(1'b0, m_initq.pop_front());
            end
         end
      end else if (m_ready(0)) begin
         m_load(req0_rs, req0_data);
         m_last = 1'b0;
         m_acc++;
      end else if (m_ready(1)) begin
         m_load(req1_rs, req1_data);
         m_last = 1'b1;
         m_acc++;
      end
   endtask

   function automatic logic [14:0] m_expect();
      return {m_starting || m_active, m_done, m_active && (m_age < HP), 1'b0,
              m_rs, m_data, m_ready(0), m_ready(1)};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {busy, init_done, EN, RW, RS, data, req0_ready, req1_ready};
   endfunction

   // Called at a negedge after inputs are driven; returns at the following negedge.
   task automatic mcycle(output obs_t o);
      #1;
      o.r0 = req0_ready; o.r1 = req1_ready; o.en = EN; o.busy = busy;
      o.rs = RS; o.idn = init_done; o.data = data;
      chk("cycle", 32'(dut_vec()), 32'(m_expect()));
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic drain();
      obs_t o;
      bit   idle = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int n = 0; n < 40 && !idle; n++) begin
         mcycle(o);
         if (!o.busy) idle = 1'b1;
      end
      chk("drain_idle", 32'(idle), 32'd1);
   endtask

   task automatic run_init();
      obs_t       o;
      logic [7:0] dq[$];
      int         hq[$], lq[$];
      int         hi = 0, lo = 0, t_rise = -1, t_done = -1;
      logic       pen = 1'b0, rs_bad = 1'b0;
      logic [7:0] exp_byte[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
      int         exp_low[4]  = '{HP, HP, 2 * HP, HP};
      for (int c = 0; c < 80 && t_done < 0; c++) begin
         mcycle(o);
         if (o.idn) begin
            t_done = c;
            lq.push_back(lo);
            chk("init_busy_fall", 32'(o.busy), 32'd0);
         end else begin
            if (o.en && !pen) begin
               if (lo > 0) lq.push_back(lo);
               lo = 0;
               dq.push_back(o.data);
               if (o.rs) rs_bad = 1'b1;
               if (t_rise < 0) t_rise = c;
            end
            if (!o.en && pen) begin
               hq.push_back(hi);
               hi = 0;
            end
            if (o.en) hi++;
            else if (t_rise >= 0) lo++;
            pen = o.en;
         end
      end
      chk("init_completed", 32'(t_done >= 0), 32'd1);
      chk("init_done_delay", 32'(t_done - t_rise), 32'd36);
      chk("init_rs_zero", 32'(rs_bad), 32'd0);
      chk("init_nbytes", 32'(dq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_byte%0d", i), 32'(dq[i]), 32'(exp_byte[i]));
         chk($sformatf("init_hi%0d", i), 32'(hq[i]), 32'(HP));
         chk($sformatf("init_lo%0d", i), 32'(lq[i]), 32'(exp_low[i]));
      end
   endtask

   typedef struct {
      logic       v0, rs0;
      logic [7:0] d0;
      logic       v1, rs1;
      logic [7:0] d1;
      logic       exp_g, exp_rs;
      logic [7:0] exp_d;
      int         exp_lo;
   } vec_t;

   task automatic apply_vec(input int idx, input vec_t v);
      obs_t o;
      bit   got = 1'b0, seen = 1'b0;
      int   hi = 0, lo = 0;
      req0_valid = v.v0; req0_rs = v.rs0; req0_data = v.d0;
      req1_valid = v.v1; req1_rs = v.rs1; req1_data = v.d1;
      for (int n = 0; n < 30 && !got; n++) begin
         mcycle(o);
         if (o.r0 | o.r1) got = 1'b1;
      end
      chk($sformatf("vec%0d_accept", idx), 32'(got), 32'd1);
      chk($sformatf("vec%0d_grant", idx), 32'({o.r0, o.r1}), 32'(v.exp_g ? 2'b01 : 2'b10));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         mcycle(o);
         if (!o.busy) seen = 1'b1;
         else if (o.en) begin
            if (hi == 0) begin
               chk($sformatf("vec%0d_data", idx), 32'(o.data), 32'(v.exp_d));
               chk($sformatf("vec%0d_rs", idx), 32'(o.rs), 32'(v.exp_rs));
            end
            hi++;
         end else lo++;
      end
      chk($sformatf("vec%0d_idle", idx), 32'(seen), 32'd1);
      chk($sformatf("vec%0d_en_hi", idx), 32'(hi), 32'(HP));
      chk($sformatf("vec%0d_en_lo", idx), 32'(lo), 32'(v.exp_lo));
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(3))
         0:       return 8'h01;
         1:       return 8'h02;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      vec_t vecs[7];
      int   grants[$], times[$];
      int   early, dut_acc;
      bit   got;

      m_acc = 0;
      m_reset();
      repeat (2) @(negedge clk);
      #1 chk("reset_state", 32'(dut_vec()), 32'h4000);
      @(negedge clk);
      rst = 1'b0;
      run_init();

      // Both requesters held valid: strict alternation, one accept per 2*HP+1 cycles.
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
      for (int c = 0; c < 60 && grants.size() < 4; c++) begin
         mcycle(o);
         if (o.r0 | o.r1) begin
            grants.push_back(o.r1 ? 1 : 0);
            times.push_back(c);
         end
      end
      chk("rr_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++)
         chk($sformatf("rr_gap%0d", i), 32'(times[i] - times[i-1]), 32'(2 * HP + 1));
      drain();

      vecs[0] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, HP};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h01, 2 * HP};
      vecs[2] = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 2 * HP};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'h01, HP};
      vecs[4] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, HP};
      vecs[5] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 8'hAA, HP};
      vecs[6] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 8'h66, HP};
      for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

      // Requests pending through init: nothing accepted early, req0 wins the first tie.
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5A;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'hA5;
      rst = 1'b1;
      m_reset();
      mcycle(o);
      mcycle(o);
      rst = 1'b0;
      early = 0;
      got   = 1'b0;
      for (int c = 0; c < 80 && !got; c++) begin
         mcycle(o);
         if ((o.r0 | o.r1) && !o.idn) early++;
         if (o.r0 | o.r1) got = 1'b1;
      end
      chk("init_ready_early", 32'(early), 32'd0);
      chk("init_req_accept", 32'(got), 32'd1);
      chk("init_req_first", 32'({o.r0, o.r1}), 32'h2);
      drain();

      dut_acc = 0;
      m_acc   = 0;
      o.r0 = 1'b0;
      o.r1 = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (req0_valid && (o.r0 || $urandom_range(15) == 0)) req0_valid = 1'b0;
         else if (!req0_valid && $urandom_range(3) == 0) begin
            req0_valid = 1'b1; req0_rs = 1'($urandom_range(1)); req0_data = rand_byte();
         end
         if (req1_valid && (o.r1 || $urandom_range(15) == 0)) req1_valid = 1'b0;
         else if (!req1_valid && $urandom_range(3) == 0) begin
            req1_valid = 1'b1; req1_rs = 1'($urandom_range(1)); req1_data = rand_byte();
         end
         mcycle(o);
         if (o.r0 | o.r1) dut_acc++;
      end
      chk("rand_accepts", 32'(dut_acc), 32'(m_acc));
      drain();

      // Reset in the middle of a request's EN-high phase.
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h48;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         mcycle(o);
         if (o.r0) got = 1'b1;
      end
      chk("mid_accept", 32'(got), 32'd1);
      req0_valid = 1'b0;
      mcycle(o);
      mcycle(o);
      chk("mid_en_high", 32'(EN), 32'd1);
      rst = 1'b1;
      m_reset();
      #1;
      chk("mid_rst_en", 32'(EN), 32'd0);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      chk("mid_rst_state", 32'(dut_vec()), 32'h4000);
      @(negedge clk);
      mcycle(o);
      rst = 1'b0;
      run_init();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
